paddle_controller: RTL and testbench

//  Parametrised paddle motion engine for the VGA pong datapath; one instance per player.

---
 rtl/paddle_if.sv | 27 ++
 rtl/paddle_controller.sv | 102 ++++++++++
 tb/tb_paddle_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_if.sv
// Button/ball inputs and paddle status outputs for one paddle_controller instance.
// The master side is the game logic; the slave side is the paddle motion engine.
interface paddle_if #(
  parameter int POS_W = 10
);
  logic             btnUp;
  logic             btnDown;
  logic             autoMode;
  logic [POS_W-1:0] ballY;
  logic             freeze;
  logic [POS_W-1:0] paddleY;
  logic             moveUp;
  logic             moveDown;
  logic             delay;
  logic             atTop;
  logic             atBottom;

  modport master (
    output btnUp, btnDown, autoMode, ballY, freeze,
    input  paddleY, moveUp, moveDown, delay, atTop, atBottom
  );

  modport slave (
    input  btnUp, btnDown, autoMode, ballY, freeze,
    output paddleY, moveUp, moveDown, delay, atTop, atBottom
  );
endinterface

// File: rtl/paddle_controller.sv
// Paddle motion engine: turns button or ball-tracking requests into paced, saturating
// vertical moves of a registered paddle position. One instance per player.
module paddle_controller #(
  parameter int POS_W        = 10,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 415,
  parameter int Y_INIT       = 208,
  parameter int STEP         = 4,
  parameter int DEADBAND     = 4,
  parameter int DELAY_CYCLES = 500000,
  parameter int CNT_W        = 20
) (
  input  logic     CLK_100MHz,
  input  logic     Reset,
  paddle_if.slave  bus
);

  localparam logic [1:0] SIDLE  = 2'd0;
  localparam logic [1:0] SUP    = 2'd1;
  localparam logic [1:0] SDOWN  = 2'd2;
  localparam logic [1:0] SDELAY = 2'd3;

  localparam logic [POS_W-1:0] YMIN_P   = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YMAX_P   = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] YINIT_P  = POS_W'(Y_INIT);
  localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
  localparam logic [POS_W:0]   DB_X     = (POS_W+1)'(DEADBAND);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);

  logic [1:0]       state_q,  state_d;
  logic [POS_W-1:0] paddle_q, paddle_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             at_top, at_bottom;
  logic [POS_W:0]   pad_x, ball_x;
  logic             auto_up, auto_dn, raw_up, raw_dn, req_up, req_dn;

  assign at_top    = (paddle_q == YMIN_P);
  assign at_bottom = (paddle_q == YMAX_P);

  // One extra bit so ballY + DEADBAND cannot wrap near the top of the range.
  assign pad_x   = {1'b0, paddle_q};
  assign ball_x  = {1'b0, bus.ballY};
  assign auto_up = pad_x > (ball_x + DB_X);
  assign auto_dn = ball_x > (pad_x + DB_X);

  assign raw_up = bus.autoMode ? auto_up : (bus.btnUp & ~bus.btnDown);
  assign raw_dn = bus.autoMode ? auto_dn : (bus.btnDown & ~bus.btnUp);
  assign req_up = raw_up & ~at_top    & ~bus.freeze;
  assign req_dn = raw_dn & ~at_bottom & ~bus.freeze;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path infers a latch.
    state_d  = state_q;
    paddle_d = paddle_q;
    cnt_d    = cnt_q;
    case (state_q)
      SIDLE: begin
        if (req_up)      state_d = SUP;
        else if (req_dn) state_d = SDOWN;
      end
      SUP: begin
        paddle_d = ((paddle_q - YMIN_P) < STEP_P) ? YMIN_P : (paddle_q - STEP_P);
        cnt_d    = '0;
        state_d  = SDELAY;
      end
      SDOWN: begin
        paddle_d = ((YMAX_P - paddle_q) < STEP_P) ? YMAX_P : (paddle_q + STEP_P);
        cnt_d    = '0;
        state_d  = SDELAY;
      end
      SDELAY: begin
        if (!bus.freeze) begin
          if (cnt_q == DLY_LAST) state_d = SIDLE;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SIDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz) begin
    // NOTE: state registers use non-blocking assignment so all of them update together.
    if (Reset) begin
      state_q  <= SIDLE;
      paddle_q <= YINIT_P;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddle_q <= paddle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.paddleY  = paddle_q;
  assign bus.moveUp   = (state_q == SUP);
  assign bus.moveDown = (state_q == SDOWN);
  assign bus.delay    = (state_q == SDELAY);
  assign bus.atTop    = at_top;
  assign bus.atBottom = at_bottom;

endmodule

// File: tb/tb_paddle_controller.sv
// Directed and randomized bench for paddle_controller, checked each cycle against a
// countdown-based reference model of the paddle's moves.
module tb_paddle_controller;

  localparam int POS_W    = 10;
  localparam int Y_MIN    = 0;
  localparam int Y_MAX    = 415;
  localparam int Y_INIT   = 208;
  localparam int STEP     = 4;
  localparam int DEADBAND = 4;
  localparam int DELAY    = 4;

  logic clk = 1'b0;
  logic rst;

  paddle_if #(.POS_W(POS_W)) bus ();

  paddle_controller #(
    .POS_W(POS_W), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_INIT(Y_INIT), .STEP(STEP),
    .DEADBAND(DEADBAND), .DELAY_CYCLES(DELAY), .CNT_W(20)
  ) dut (
    .CLK_100MHz(clk),
    .Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_rem counts cycles left before the engine is idle again.
  // DELAY+1 means the move-pulse cycle; 1..DELAY are the waiting cycles.
  int m_pos;
  int m_rem;
  bit m_dir_up;

  int up_pulses, dn_pulses, dly_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit ru, rd;
    int by;
    by = int'(bus.ballY);
    if (rst) begin
      m_pos = Y_INIT;
      m_rem = 0;
    end else if (m_rem == 0) begin
      if (bus.autoMode) begin
        ru = m_pos > by + DEADBAND;
        rd = by > m_pos + DEADBAND;
      end else begin
        ru = bus.btnUp && !bus.btnDown;
        rd = bus.btnDown && !bus.btnUp;
      end
      ru = ru && (m_pos != Y_MIN) && !bus.freeze;
      rd = rd && (m_pos != Y_MAX) && !bus.freeze;
      if (ru) begin
        m_rem = DELAY + 1; m_dir_up = 1'b1;
      end else if (rd) begin
        m_rem = DELAY + 1; m_dir_up = 1'b0;
      end
    end else if (m_rem == DELAY + 1) begin
      if (m_dir_up) m_pos = (m_pos - STEP < Y_MIN) ? Y_MIN : m_pos - STEP;
      else          m_pos = (m_pos + STEP > Y_MAX) ? Y_MAX : m_pos + STEP;
      m_rem = DELAY;
    end else if (!bus.freeze) begin
      m_rem--;
    end
  endfunction

  task automatic compare_model();
    check("paddleY",  bus.paddleY,  m_pos);
    check("moveUp",   bus.moveUp,   (m_rem == DELAY + 1) && m_dir_up);
    check("moveDown", bus.moveDown, (m_rem == DELAY + 1) && !m_dir_up);
    check("delay",    bus.delay,    (m_rem >= 1) && (m_rem <= DELAY));
    check("atTop",    bus.atTop,    m_pos == Y_MIN);
    check("atBottom", bus.atBottom, m_pos == Y_MAX);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
    if (bus.moveUp === 1'b1)   up_pulses++;
    if (bus.moveDown === 1'b1) dn_pulses++;
    if (bus.delay === 1'b1)    dly_cycles++;
  endtask

  task automatic clear_counts();
    up_pulses  = 0;
    dn_pulses  = 0;
    dly_cycles = 0;
  endtask

  initial begin
    int hold;
    rst          = 1'b1;
    bus.btnUp    = 1'b0;
    bus.btnDown  = 1'b0;
    bus.autoMode = 1'b0;
    bus.ballY    = '0;
    bus.freeze   = 1'b0;
    m_pos        = Y_INIT;
    m_rem        = 0;
    m_dir_up     = 1'b0;
    clear_counts();

    // Reset state
    repeat (2) cyc();
    rst = 1'b0;
    check("rst_paddleY",  bus.paddleY,  208);
    check("rst_moveUp",   bus.moveUp,   0);
    check("rst_moveDown", bus.moveDown, 0);
    check("rst_delay",    bus.delay,    0);
    check("rst_atTop",    bus.atTop,    0);
    check("rst_atBottom", bus.atBottom, 0);

    // Held btnUp: one move every DELAY+2 cycles
    bus.btnUp = 1'b1;
    clear_counts();
    repeat (20) cyc();
    check("hold_up_pulses",  up_pulses,   4);
    check("hold_up_paddleY", bus.paddleY, 192);
    check("hold_up_delay",   dly_cycles,  13);
    bus.btnUp = 1'b0;
    repeat (6) cyc();

    // Both buttons: no request
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.btnUp   = 1'b1;
    bus.btnDown = 1'b1;
    clear_counts();
    repeat (20) cyc();
    check("both_pulses",  up_pulses + dn_pulses, 0);
    check("both_paddleY", bus.paddleY, 208);
    check("both_delay",   dly_cycles, 0);

    // Saturate at the bottom, then at the top
    bus.btnUp = 1'b0;
    for (int i = 0; i < 400 && bus.atBottom !== 1'b1; i++) cyc();
    check("bottom_reached", bus.atBottom, 1);
    check("bottom_paddleY", bus.paddleY, 415);
    clear_counts();
    repeat (20) cyc();
    check("bottom_no_pulse", dn_pulses, 0);

    bus.btnDown = 1'b0;
    bus.btnUp   = 1'b1;
    for (int i = 0; i < 800 && bus.atTop !== 1'b1; i++) cyc();
    check("top_reached", bus.atTop, 1);
    check("top_paddleY", bus.paddleY, 0);
    clear_counts();
    repeat (20) cyc();
    check("top_no_pulse", up_pulses, 0);

    // Auto tracking toward ballY=300 with btnUp ignored
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.autoMode = 1'b1;
    bus.ballY    = 10'd300;
    clear_counts();
    repeat (160) cyc();
    check("auto_dn_pulses", dn_pulses, 22);
    check("auto_up_pulses", up_pulses, 0);
    check("auto_paddleY",   bus.paddleY, 296);

    // Freeze during the delay phase
    bus.autoMode = 1'b0;
    bus.btnUp    = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.btnDown = 1'b1;
    cyc();
    bus.btnDown = 1'b0;
    repeat (2) cyc();
    bus.freeze = 1'b1;
    clear_counts();
    repeat (10) cyc();
    check("freeze_delay_held", dly_cycles, 10);
    check("freeze_paddleY",    bus.paddleY, 212);
    bus.freeze = 1'b0;
    clear_counts();
    repeat (4) cyc();
    check("freeze_resume_delay", dly_cycles, 2);

    // Reset in the middle of the delay phase
    bus.btnDown = 1'b1;
    cyc();
    bus.btnDown = 1'b0;
    repeat (2) cyc();
    check("pre_rst_paddleY", bus.paddleY, 216);
    rst = 1'b1;
    cyc();
    check("mid_rst_paddleY", bus.paddleY, 208);
    check("mid_rst_delay",   bus.delay, 0);
    check("mid_rst_moveUp",  bus.moveUp, 0);
    rst = 1'b0;

    // Randomized inputs held for short random spans
    for (int n = 0; n < 120; n++) begin
      rst          = ($urandom_range(0, 40) == 0);
      bus.btnUp    = 1'($urandom_range(0, 1));
      bus.btnDown  = 1'($urandom_range(0, 1));
      bus.autoMode = ($urandom_range(0, 2) == 0);
      bus.freeze   = ($urandom_range(0, 7) == 0);
      bus.ballY    = 10'($urandom_range(0, 1023));
      hold         = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        cyc();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
